gelato_warp_issue_scheduler: RTL and testbench
==============================================

GELATO_WARP_ISSUE_SCHEDULER -- requirements
Module: gelato_warp_issue_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_WARPS, default 4, meaning the number of per-warp instruction buffers arbitrated (power of two, >=2).
REQ-002 The block SHALL have parameter INST_W, default 32, meaning the decoded instruction payload width.
REQ-003 The block SHALL have localparam WARP_ID_W = $clog2(NUM_WARPS).
REQ-004 The block SHALL have these ports (one per line: name, direction, width, meaning), clock and reset first:
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, synchronous, active-high.
  rdy  in  1  global enable; when low, no state changes.
  warp_active_i  in  NUM_WARPS  warp enabled by dispatcher.
  ibuf_valid_i  in  NUM_WARPS  per-warp buffer head valid.
  ibuf_inst_i  in  NUM_WARPS x INST_W  per-warp head instruction.
  sb_ready_i  in  NUM_WARPS  scoreboard: head has no hazard.
  ibuf_pop_o  out  NUM_WARPS  one-hot pop of granted buffer head.
  flush_i  in  1  discard the held issue slot.
  issue_valid_o  out  1  issue slot holds an instruction.
  issue_ready_i  in  1  execute stage accepts the slot.
  issue_warp_id_o  out  WARP_ID_W  warp of held instruction.
  issue_inst_o  out  INST_W  held instruction.
  stall_cnt_o  out  32  saturating count of back-pressure cycles.

Function
REQ-005 Warp w SHALL be eligible when warp_active_i[w] & ibuf_valid_i[w] & sb_ready_i[w].
REQ-006 The issue slot SHALL be free when !issue_valid_o || issue_ready_i; a grant SHALL occur only when rdy, slot free, flush_i low and at least one warp is eligible.
REQ-007 Default arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_WARPS, first eligible warp wins.
REQ-008 On grant, ibuf_pop_o SHALL be one-hot at the granted warp in the same cycle (combinational); otherwise ibuf_pop_o SHALL be all-zero.
REQ-009 On grant, the slot SHALL load warp id and ibuf_inst_i[granted] at the clock edge; issue_valid_o asserts next cycle (latency 1 cycle, eligible -> valid).
REQ-010 On grant, last_grant SHALL update to the granted id; with no grant last_grant SHALL hold.
REQ-011 Handshake: while issue_valid_o && !issue_ready_i, issue_valid_o, issue_warp_id_o, issue_inst_o SHALL stay stable.
REQ-012 Accept and new grant in the same cycle SHALL give back-to-back issue (one instruction per cycle); accept with no eligible warp SHALL clear issue_valid_o next cycle.
REQ-013 flush_i (when rdy) SHALL clear issue_valid_o next cycle and suppress grant and pop that cycle; flush_i wins over issue_ready_i.
REQ-014 Deasserting warp_active_i for a warp whose instruction already occupies the slot SHALL NOT remove it; only flush_i removes it.
REQ-015 stall_cnt_o SHALL increment by 1 each rdy cycle with issue_valid_o && !issue_ready_i && !flush_i, saturating at 32'hFFFF_FFFF.
REQ-016 When rdy is low: no grant, ibuf_pop_o all-zero, all registers hold.

Reset
REQ-017 With rst high at a clock edge: issue_valid_o=0, issue_warp_id_o=0, issue_inst_o=0, stall_cnt_o=0, last_grant=NUM_WARPS-1 (warp 0 first priority); rst overrides rdy and flush_i.
REQ-018 During the reset cycle ibuf_pop_o SHALL be all-zero; an instruction held mid-handshake is dropped.

Configuration
REQ-019 Macro GELATO_SCHED_GREEDY_EN defined: if the warp at last_grant is eligible it SHALL be granted again (greedy-then-round-robin); otherwise REQ-007 applies.
REQ-020 Macro GELATO_SCHED_GREEDY_EN undefined: pure round-robin per REQ-007.

Structure
REQ-021 Package gelato_sched_pkg SHALL hold the warp_id_t typedef, the issue-slot struct (valid, warp id, inst) and the default NUM_WARPS/INST_W constants.
REQ-022 The rotating priority search SHALL be sub-module gelato_rr_arbiter (req vector, pointer, greedy enable -> one-hot grant, id, any-grant).

Verification
REQ-023 After reset, all 4 warps eligible, issue_ready_i=1 -> issue_warp_id_o sequence 0,1,2,3,0 on consecutive cycles, one pop per cycle.
REQ-024 Warp 2 eligible, issue_ready_i=0 for 5 cycles -> slot stable with warp 2, ibuf_pop_o[2] pulses once, stall_cnt_o=5.
REQ-025 Slot holds warp 1, flush_i=1 with issue_ready_i=1 -> issue_valid_o=0 next cycle, no pop that cycle, stall_cnt_o unchanged.
REQ-026 GELATO_SCHED_GREEDY_EN defined, warps 0 and 3 eligible, ready=1 -> warp 0 issued repeatedly; when sb_ready_i[0]=0 -> warp 3 next.
REQ-027 rdy=0 for 3 cycles with eligible warps -> no pops, outputs and stall_cnt_o frozen; rst mid-stall -> all outputs zero next cycle.

Source files
------------

// File: rtl/gelato_sched_pkg.sv
// Shared types and default sizing for the gelato warp issue scheduler.
package gelato_sched_pkg;

  localparam int DEF_NUM_WARPS = 4;
  localparam int DEF_INST_W    = 32;
  localparam int DEF_WARP_ID_W = $clog2(DEF_NUM_WARPS);

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  typedef logic [DEF_WARP_ID_W-1:0] warp_id_t;

  typedef struct packed {
    logic                  valid;
    warp_id_t              warp_id;
    logic [DEF_INST_W-1:0] inst;
  } issue_slot_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Rotating-priority arbiter: first requester after ptr wins, ptr itself last
// unless greedy_en lets the previous winner keep the grant.
module gelato_rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         greedy_en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_id = ptr;
    idx    = ptr;
    any    = |req;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int i = N; i >= 1; i--) begin
      idx = ptr + W'(i);
      if (req[idx]) gnt_id = idx;
    end
    if (greedy_en && req[ptr]) gnt_id = ptr;
    gnt = any ? (N'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/gelato_warp_issue_scheduler.sv
// Warp issue scheduler: picks one eligible warp per cycle into a single issue slot.
// Define GELATO_SCHED_GREEDY_EN for greedy-then-round-robin arbitration.
module gelato_warp_issue_scheduler
  import gelato_sched_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int INST_W    = DEF_INST_W,
  localparam int WARP_ID_W = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [NUM_WARPS-1:0]        warp_active_i,
  input  logic [NUM_WARPS-1:0]        ibuf_valid_i,
  input  logic [NUM_WARPS*INST_W-1:0] ibuf_inst_i,
  input  logic [NUM_WARPS-1:0]        sb_ready_i,
  output logic [NUM_WARPS-1:0]        ibuf_pop_o,
  input  logic                        flush_i,
  output logic                        issue_valid_o,
  input  logic                        issue_ready_i,
  output logic [WARP_ID_W-1:0]        issue_warp_id_o,
  output logic [INST_W-1:0]           issue_inst_o,
  output logic [31:0]                 stall_cnt_o
);

`ifdef GELATO_SCHED_GREEDY_EN
  localparam logic GREEDY = 1'b1;
`else
  localparam logic GREEDY = 1'b0;
`endif

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] arb_gnt;
  logic [WARP_ID_W-1:0] arb_id;
  logic                 arb_any;
  logic [WARP_ID_W-1:0] last_grant;
  logic                 slot_free;
  logic                 grant;
  logic [INST_W-1:0]    inst_sel;

  assign eligible = warp_active_i & ibuf_valid_i & sb_ready_i;

  gelato_rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req       (eligible),
    .ptr       (last_grant),
    .greedy_en (GREEDY),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .any       (arb_any)
  );

  // Handshake: the slot transfers on issue_valid_o && issue_ready_i; while
  // valid is high and ready low the slot contents are held unchanged.
  // flush_i overrides ready and empties the slot without a transfer.
  assign slot_free  = !issue_valid_o || issue_ready_i;
  assign grant      = rdy && !rst && slot_free && !flush_i && arb_any;
  assign ibuf_pop_o = grant ? arb_gnt : '0;

  always_comb begin
    inst_sel = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (arb_id == WARP_ID_W'(w)) inst_sel = ibuf_inst_i[w*INST_W +: INST_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_o   <= 1'b0;
      issue_warp_id_o <= '0;
      issue_inst_o    <= '0;
      stall_cnt_o     <= '0;
      last_grant      <= WARP_ID_W'(NUM_WARPS - 1);
    end else if (rdy) begin
      if (issue_valid_o && !issue_ready_i && !flush_i && stall_cnt_o != STALL_MAX)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i) begin
        issue_valid_o <= 1'b0;
      end else if (grant) begin
        issue_valid_o   <= 1'b1;
        issue_warp_id_o <= arb_id;
        issue_inst_o    <= inst_sel;
        last_grant      <= arb_id;
      end else if (issue_ready_i) begin
        issue_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gelato_warp_issue_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_gelato_warp_issue_scheduler;

  localparam int NW = 4;
  localparam int IW = 32;
  localparam int WW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [NW-1:0]     warp_active_i;
  logic [NW-1:0]     ibuf_valid_i;
  logic [NW*IW-1:0]  ibuf_inst_i;
  logic [NW-1:0]     sb_ready_i;
  logic [NW-1:0]     ibuf_pop_o;
  logic              flush_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [WW-1:0]     issue_warp_id_o;
  logic [IW-1:0]     issue_inst_o;
  logic [31:0]       stall_cnt_o;

  int checks = 0;
  int failures = 0;

  // Model state: the slot is a queue holding at most one {warp, inst} entry.
  logic [WW+IW-1:0] exp_q[$];
  logic [31:0]      m_stall = 0;
  int               m_last = NW - 1;
  bit               after_rst = 0;

  gelato_warp_issue_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .warp_active_i   (warp_active_i),
    .ibuf_valid_i    (ibuf_valid_i),
    .ibuf_inst_i     (ibuf_inst_i),
    .sb_ready_i      (sb_ready_i),
    .ibuf_pop_o      (ibuf_pop_o),
    .flush_i         (flush_i),
    .issue_valid_o   (issue_valid_o),
    .issue_ready_i   (issue_ready_i),
    .issue_warp_id_o (issue_warp_id_o),
    .issue_inst_o    (issue_inst_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NW-1:0] elig, input int last);
`ifdef GELATO_SCHED_GREEDY_EN
    if (elig[last]) return last;
`endif
    for (int k = 1; k <= NW; k++) begin
      if (elig[(last + k) % NW]) return (last + k) % NW;
    end
    return -1;
  endfunction

  task automatic apply(input logic r, input logic en, input logic [NW-1:0] act,
                       input logic [NW-1:0] vld, input logic [NW-1:0] sbr,
                       input logic ready, input logic fl);
    logic [NW-1:0] elig;
    logic [NW-1:0] exp_pop;
    logic [IW-1:0] insts[NW];
    bit            slot_full;
    bit            grant;
    int            w;
    @(negedge clk);
    rst = r; rdy = en; warp_active_i = act; ibuf_valid_i = vld;
    sb_ready_i = sbr; issue_ready_i = ready; flush_i = fl;
    for (int i = 0; i < NW; i++) begin
      insts[i] = $urandom;
      ibuf_inst_i[i*IW +: IW] = insts[i];
    end
    #1;
    elig      = act & vld & sbr;
    slot_full = exp_q.size() != 0;
    w         = pick(elig, m_last);
    grant     = !r && en && (!slot_full || ready) && !fl && (w >= 0);
    exp_pop   = grant ? (NW'(1) << w) : '0;

    check("pop", 64'(ibuf_pop_o), 64'(exp_pop));
    check("valid", 64'(issue_valid_o), 64'(slot_full));
    if (slot_full) begin
      check("warp_id", 64'(issue_warp_id_o), 64'(exp_q[0][WW+IW-1:IW]));
      check("inst", 64'(issue_inst_o), 64'(exp_q[0][IW-1:0]));
    end
    if (after_rst) begin
      check("rst_warp_id", 64'(issue_warp_id_o), 64'd0);
      check("rst_inst", 64'(issue_inst_o), 64'd0);
    end
    check("stall", 64'(stall_cnt_o), 64'(m_stall));

    after_rst = r;
    if (r) begin
      exp_q.delete();
      m_stall = 0;
      m_last  = NW - 1;
    end else if (en) begin
      if (slot_full && !ready && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (slot_full && ready) void'(exp_q.pop_front());
        if (grant) begin
          exp_q.push_back({WW'(w), insts[w]});
          m_last = w;
        end
      end
    end
  endtask

  initial begin
    rst = 1; rdy = 0; warp_active_i = 0; ibuf_valid_i = 0; ibuf_inst_i = 0;
    sb_ready_i = 0; flush_i = 0; issue_ready_i = 0;

    // Reset with flush and rdy asserted; reset must win.
    apply(1, 1, 4'hF, 4'hF, 4'hF, 1, 1);
    apply(1, 0, 4'hF, 4'hF, 4'hF, 0, 0);

    // All warps eligible, execute always ready: 0,1,2,3,0,...
    for (int i = 0; i < 7; i++) apply(0, 1, 4'hF, 4'hF, 4'hF, 1, 0);

    // Warp 2 alone under back-pressure for 5 cycles.
    apply(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) apply(0, 1, 4'h4, 4'h4, 4'h4, 0, 0);
    apply(0, 1, 4'h0, 4'h0, 4'h0, 1, 0);
    check("stall_after_5", 64'(stall_cnt_o), 64'd5);

    // Warp 1 in slot, then flush together with ready.
    apply(1, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 4'h2, 4'h2, 4'h2, 1, 0);
    apply(0, 1, 4'hF, 4'hF, 4'hF, 1, 1);
    apply(0, 1, 4'h0, 4'h0, 4'h0, 1, 0);
    check("flush_clears", 64'(issue_valid_o), 64'd0);

    // Greedy preference check: warps 0 and 3 eligible, then drop 0.
    apply(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(0, 1, 4'h9, 4'h9, 4'h9, 1, 0);
    for (int i = 0; i < 2; i++) apply(0, 1, 4'h9, 4'h9, 4'h8, 1, 0);

    // rdy low freezes everything; reset mid-stall clears it.
    apply(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 4'hF, 4'hF, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 4'hF, 4'hF, 4'hF, 1, 0);
    apply(1, 0, 4'hF, 4'hF, 4'hF, 0, 0);
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    check("rst_valid", 64'(issue_valid_o), 64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            NW'($urandom_range(0, 15)) | 4'h3,
            NW'($urandom_range(0, 15)),
            NW'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
